// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which requester owns the current/last grant
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, memory-stage and cache-side signals of the arbiter.
//   slave  : arbiter view (takes requests and cache responses, drives cache and dones)
//   master : environment view (requesters plus cache)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) ();

  // Fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_done;
  // Memory-stage side
  logic              dm_req;
  logic              dm_wr_en;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wr_value;
  logic [DATA_W-1:0] dm_data;
  logic              dm_done;
  // Pipeline control
  logic              flush;
  // Cache side
  logic              mem_enable;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_value;
  logic [DATA_W-1:0] mem_data;
  logic              mem_complete;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr_en, dm_addr, dm_wr_value, flush,
    input  mem_data, mem_complete,
    output if_data, if_done, dm_data, dm_done,
    output mem_enable, mem_wr_en, mem_addr, mem_wr_value
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wr_en, dm_addr, dm_wr_value, flush,
    output mem_data, mem_complete,
    input  if_data, if_done, dm_data, dm_done,
    input  mem_enable, mem_wr_en, mem_addr, mem_wr_value
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Combinational winner select for the shared memory port.
//   eff_if_i      : fetch request qualified by !flush
//   dm_req_i      : memory-stage request
//   streak_i      : consecutive data grants while fetch was waiting
//   grant_valid_o : some requester wins this cycle
//   grant_owner_o : winner (data by default, fetch once the streak hits STARVE_MAX)
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned StreakW    = $clog2(STARVE_MAX + 1)
) (
  input  logic               eff_if_i,
  input  logic               dm_req_i,
  input  logic [StreakW-1:0] streak_i,
  output logic               grant_valid_o,
  output owner_e             grant_owner_o
);

  localparam logic [StreakW-1:0] StreakLim = StreakW'(STARVE_MAX);

  always_comb begin
    grant_valid_o = eff_if_i | dm_req_i;
    grant_owner_o = OWN_D;
    if (eff_if_i && (!dm_req_i || (streak_i == StreakLim))) begin
      grant_owner_o = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache port between instruction fetch and the memory stage.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : fetch/data request channels, flush, and the cache handshake
//   busy     : a transaction is in flight (BUSY or RESP)
//   owner_d  : current/last grant went to the data side
// The winner's command is registered onto mem_*; mem_enable is held until
// mem_complete, then the owner gets a one-cycle done pulse with the read data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus,
  output logic               busy,
  output logic               owner_d
);

  localparam int unsigned        StreakW   = $clog2(STARVE_MAX + 1);
  localparam logic [StreakW-1:0] StreakLim = StreakW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  owner_e            grant_owner_q, grant_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_value_q, wr_value_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] dm_data_q, dm_data_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic              kill_q, kill_d;

  logic   eff_if;
  logic   grant_valid;
  owner_e grant_owner;

  assign eff_if = bus.if_req & ~bus.flush;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .eff_if_i     (eff_if),
    .dm_req_i     (bus.dm_req),
    .streak_i     (streak_q),
    .grant_valid_o(grant_valid),
    .grant_owner_o(grant_owner)
  );

  // FSM next state and data registers
  always_comb begin
    state_d       = state_q;
    grant_owner_d = grant_owner_q;
    addr_d        = addr_q;
    wr_en_d       = wr_en_q;
    wr_value_d    = wr_value_q;
    if_data_d     = if_data_q;
    dm_data_d     = dm_data_q;
    kill_d        = kill_q;

    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          grant_owner_d = grant_owner;
          state_d       = ARB_BUSY;
          if (grant_owner == OWN_D) begin
            addr_d     = bus.dm_addr;
            wr_en_d    = bus.dm_wr_en;
            wr_value_d = bus.dm_wr_value;
          end else begin
            addr_d     = bus.if_addr;
            wr_en_d    = 1'b0;
            wr_value_d = '0;
          end
        end
      end
      ARB_BUSY: begin
        if (bus.flush && (grant_owner_q == OWN_I)) begin
          kill_d = 1'b1;
        end
        if (bus.mem_complete) begin
          state_d = ARB_RESP;
          if (grant_owner_q == OWN_D) begin
            dm_data_d = bus.mem_data;
          end else if (!kill_d) begin
            // A flush in the completing cycle already kills this fetch.
            if_data_d = bus.mem_data;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        kill_d  = 1'b0;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Starvation streak: counts data wins over a live fetch, reset once fetch is served or gone.
  always_comb begin
    streak_d = streak_q;
    if (!bus.if_req) begin
      streak_d = '0;
    end else if ((state_q == ARB_IDLE) && grant_valid) begin
      if (grant_owner == OWN_I) begin
        streak_d = '0;
      end else if (eff_if && (streak_q != StreakLim)) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_owner_q <= OWN_I;
      addr_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_value_q    <= '0;
      if_data_q     <= '0;
      dm_data_q     <= '0;
      streak_q      <= '0;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_owner_q <= grant_owner_d;
      addr_q        <= addr_d;
      wr_en_q       <= wr_en_d;
      wr_value_q    <= wr_value_d;
      if_data_q     <= if_data_d;
      dm_data_q     <= dm_data_d;
      streak_q      <= streak_d;
      kill_q        <= kill_d;
    end
  end

  always_comb begin
    bus.mem_enable   = (state_q == ARB_BUSY);
    bus.mem_wr_en    = wr_en_q;
    bus.mem_addr     = addr_q;
    bus.mem_wr_value = wr_value_q;
    bus.if_data      = if_data_q;
    bus.dm_data      = dm_data_q;
    bus.if_done      = (state_q == ARB_RESP) && (grant_owner_q == OWN_I) && !kill_q;
    bus.dm_done      = (state_q == ARB_RESP) && (grant_owner_q == OWN_D);
    busy             = (state_q != ARB_IDLE);
    owner_d          = grant_owner_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// phase, all compared cycle by cycle against a transaction-level reference.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SM = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  logic owner_d;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SM)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .owner_d(owner_d)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Requesters and cache environment
  bit          if_pend, dm_pend, dm_wr;
  logic [63:0] if_a, dm_a, dm_v;
  bit          seen_if_done, seen_dm_done;
  int          p_if, p_dm, p_flush, p_stray;
  int          cache_delay;  // -1 picks a random 0..3 per transaction
  int          cache_wait;
  bit          force_flush;
  bit          use_fixed_data;
  logic [63:0] fixed_data;
  int          if_done_cnt, dm_done_cnt, enable_cnt;
  bit          prev_enable;
  int          grant_log[$];

  // Reference: one outstanding transaction at a time
  bit          m_active, m_resp, m_killed, m_owner, m_wr;
  logic [63:0] m_addr, m_val, m_if_data, m_dm_data;
  int          m_streak;

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_active  = 0;
    m_resp    = 0;
    m_killed  = 0;
    m_owner   = 0;
    m_wr      = 0;
    m_addr    = '0;
    m_val     = '0;
    m_if_data = '0;
    m_dm_data = '0;
    m_streak  = 0;
    if_pend      = 0;
    dm_pend      = 0;
    seen_if_done = 0;
    seen_dm_done = 0;
    cache_wait   = -1;
    prev_enable  = 0;
  endtask

  task automatic drive();
    bit flush_now;
    if (seen_if_done) if_pend = 0;
    if (seen_dm_done) dm_pend = 0;
    if (!if_pend && ($urandom_range(0, 99) < p_if)) begin
      if_pend = 1;
      if_a    = rand64();
    end
    if (!dm_pend && ($urandom_range(0, 99) < p_dm)) begin
      dm_pend = 1;
      dm_wr   = $urandom_range(0, 1) == 1;
      dm_a    = rand64();
      dm_v    = rand64();
    end
    flush_now   = force_flush || ($urandom_range(0, 99) < p_flush);
    force_flush = 0;
    // A flush redirects fetch: the held request becomes a new fetch target.
    if (flush_now && if_pend) if_a = rand64();
    bus.mem_complete = 1'b0;
    if (bus.mem_enable) begin
      if (cache_wait < 0) cache_wait = (cache_delay < 0) ? $urandom_range(0, 3) : cache_delay;
      if (cache_wait == 0) begin
        bus.mem_complete = 1'b1;
        cache_wait       = -1;
      end else begin
        cache_wait--;
      end
    end else begin
      cache_wait = -1;
      if ($urandom_range(0, 99) < p_stray) bus.mem_complete = 1'b1;
    end
    bus.mem_data    = use_fixed_data ? fixed_data : rand64();
    bus.if_req      = if_pend;
    bus.if_addr     = if_a;
    bus.dm_req      = dm_pend;
    bus.dm_wr_en    = dm_wr;
    bus.dm_addr     = dm_a;
    bus.dm_wr_value = dm_v;
    bus.flush       = flush_now;
  endtask

  task automatic observe();
    bit exp_en, exp_ifd, exp_dmd, eff_if, win_i;
    exp_en  = m_active && !m_resp;
    exp_ifd = m_resp && !m_owner && !m_killed;
    exp_dmd = m_resp && m_owner;
    check_eq("mem_enable", bus.mem_enable, exp_en);
    check_eq("if_done", bus.if_done, exp_ifd);
    check_eq("dm_done", bus.dm_done, exp_dmd);
    check_eq("busy", busy, m_active);
    check_eq("owner_d", owner_d, m_owner);
    check_eq("mem_addr", bus.mem_addr, m_addr);
    check_eq("mem_wr_en", bus.mem_wr_en, m_wr);
    check_eq("mem_wr_value", bus.mem_wr_value, m_val);
    check_eq("if_data", bus.if_data, m_if_data);
    check_eq("dm_data", bus.dm_data, m_dm_data);

    seen_if_done = bus.if_done;
    seen_dm_done = bus.dm_done;
    if (bus.if_done) if_done_cnt++;
    if (bus.dm_done) dm_done_cnt++;
    if (bus.mem_enable) enable_cnt++;
    if (bus.mem_enable && !prev_enable) grant_log.push_back(int'(owner_d));
    prev_enable = bus.mem_enable;

    // Advance the reference by one clock
    eff_if = bus.if_req && !bus.flush;
    win_i  = 0;
    if (m_resp) begin
      m_active = 0;
      m_resp   = 0;
      m_killed = 0;
    end else if (m_active) begin
      if (bus.flush && !m_owner) m_killed = 1;
      if (bus.mem_complete) begin
        m_resp = 1;
        if (m_owner) m_dm_data = bus.mem_data;
        else if (!m_killed) m_if_data = bus.mem_data;
      end
    end else if (eff_if || bus.dm_req) begin
      win_i    = eff_if && (!bus.dm_req || (m_streak == int'(SM)));
      m_active = 1;
      m_owner  = !win_i;
      m_addr   = win_i ? bus.if_addr : bus.dm_addr;
      m_wr     = win_i ? 1'b0 : bus.dm_wr_en;
      m_val    = win_i ? '0 : bus.dm_wr_value;
      if (!win_i && eff_if && (m_streak < int'(SM))) m_streak++;
    end
    if (!bus.if_req || win_i) m_streak = 0;
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic quiet();
    p_if = 0; p_dm = 0; p_flush = 0; p_stray = 0;
    if_done_cnt = 0; dm_done_cnt = 0; enable_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    int exp_order[6];
    exp_order = '{1, 1, 0, 1, 1, 0};
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_wr_en = 0;
    bus.dm_addr = '0; bus.dm_wr_value = '0; bus.flush = 0;
    bus.mem_data = '0; bus.mem_complete = 0;
    if_a = '0; dm_a = '0; dm_v = '0; dm_wr = 0; force_flush = 0;
    use_fixed_data = 0; fixed_data = '0; cache_delay = 0;
    quiet();
    model_reset();

    // Asynchronous reset values, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mem_enable", bus.mem_enable, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_owner_d", owner_d, 0);
    check_eq("rst_if_done", bus.if_done, 0);
    check_eq("rst_dm_done", bus.dm_done, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_if_data", bus.if_data, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch, cache completes 3 cycles after enable
    quiet();
    cache_delay = 3; use_fixed_data = 1; fixed_data = 64'hDEAD;
    if_pend = 1; if_a = 64'h1000;
    run(10);
    check_eq("t1_if_done_cnt", if_done_cnt, 1);
    check_eq("t1_dm_done_cnt", dm_done_cnt, 0);
    check_eq("t1_if_data", bus.if_data, 64'hDEAD);
    check_eq("t1_mem_addr", bus.mem_addr, 64'h1000);
    check_eq("t1_enable_cnt", enable_cnt, 4);

    // Store
    quiet();
    cache_delay = 2;
    dm_pend = 1; dm_wr = 1; dm_a = 64'h2008; dm_v = 64'h55;
    run(10);
    check_eq("t2_dm_done_cnt", dm_done_cnt, 1);
    check_eq("t2_mem_wr_en", bus.mem_wr_en, 1);
    check_eq("t2_mem_wr_value", bus.mem_wr_value, 64'h55);
    check_eq("t2_enable_cnt", enable_cnt, 3);

    // Cache completes in the first enable cycle: done two cycles after the request
    quiet();
    cache_delay = 0; use_fixed_data = 0;
    dm_pend = 1; dm_wr = 0; dm_a = 64'h3000;
    done_at = -1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (seen_dm_done && (done_at < 0)) done_at = i;
    end
    check_eq("t3_latency", done_at, 2);
    check_eq("t3_enable_cnt", enable_cnt, 1);

    // Flush in IDLE blocks the fetch grant; flush in BUSY kills the fetch
    quiet();
    cache_delay = 3;
    if_pend = 1; if_a = 64'h4000; force_flush = 1;
    cycle();
    check_eq("t4_no_grant", busy, 0);
    cycle();
    check_eq("t4_granted", busy, 1);
    cycle();
    force_flush = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (!busy) break;
    end
    check_eq("t4_killed_idle", busy, 0);
    check_eq("t4_killed_no_done", if_done_cnt, 0);
    run(10);
    check_eq("t4_next_done", if_done_cnt, 1);

    // Reset mid-BUSY, then a late completion must not produce a done
    quiet();
    dm_pend = 1; dm_wr = 0; dm_a = 64'h5000;
    cycle();
    cycle();
    check_eq("t5_in_busy", bus.mem_enable, 1);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_enable", bus.mem_enable, 0);
    check_eq("t5_rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    p_stray = 100;
    run(5);
    check_eq("t5_late_if_done", if_done_cnt, 0);
    check_eq("t5_late_dm_done", dm_done_cnt, 0);

    // Both requesters always asking: starvation bound of 2
    quiet();
    cache_delay = 0;
    p_if = 100; p_dm = 100;
    grant_log.delete();
    for (int i = 0; i < 40; i++) begin
      if (grant_log.size() >= 6) break;
      cycle();
    end
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t6_order%0d", i), (i < grant_log.size()) ? grant_log[i] : -1,
               exp_order[i]);
    end
    p_if = 0; p_dm = 0;
    run(10);

    // Random traffic with flushes, variable cache latency and stray completions
    quiet();
    cache_delay = -1;
    p_if = 40; p_dm = 40; p_flush = 8; p_stray = 5;
    run(2000);
    p_if = 0; p_dm = 0; p_flush = 0; p_stray = 0;
    run(20);
    check_eq("t7_drained", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single cache/memory port between instruction fetch and the memory stage. Each requester uses a hold-until-done request interface. The block arbitrates and registers the winner's command. It drives the cache enable/complete handshake and returns read data with a one-cycle done pulse. Data accesses win by default, with a starvation bound for fetch. Fetch results are discarded on pipeline flush.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- STARVE_MAX, 4, max consecutive data grants while fetch waits (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_data  out  DATA_W  fetch read data, valid with if_done
- if_done  out  1  one-cycle fetch completion pulse
- dm_req  in  1  memory-stage request, held until dm_done
- dm_wr_en  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wr_value  in  DATA_W  store data
- dm_data  out  DATA_W  load data, valid with dm_done
- dm_done  out  1  one-cycle data completion pulse (loads and stores)
- flush  in  1  pipeline flush; kills fetch only
- mem_enable  out  1  cache request active
- mem_wr_en  out  1  cache write
- mem_addr  out  ADDR_W  cache address
- mem_wr_value  out  DATA_W  cache write data
- mem_data  in  DATA_W  cache read data, valid with mem_complete
- mem_complete  in  1  cache completion, one cycle
- busy  out  1  state != IDLE
- owner_d  out  1  current/last grant is data side

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: requests are qualified as eff_if = if_req & !flush and dm_req.
  - Neither qualified: stay in IDLE.
  - Only one qualified: grant it.
  - Both qualified: grant data unless streak == STARVE_MAX, then grant fetch.
  - On a grant, latch address, wr_en and wr_value into the mem_* registers. Fetch always sets wr_en = 0 and wr_value = 0. Go to BUSY.
- BUSY: mem_enable = 1 and all mem_* outputs are held constant.
  - mem_complete: capture mem_data into if_data or dm_data per owner. Go to RESP. mem_enable drops to 0 from the RESP cycle on.
- RESP: pulse done for the owner for one cycle, then go to IDLE.
  - Fetch owner with kill set: no if_done, if_data is left unchanged.
  - Clear kill.
- Kill: set when flush is high in BUSY with a fetch owner. Flush in the RESP cycle does not cancel an already-issued if_done.
- Data transactions are never affected by flush.
- Streak counter (width $clog2(STARVE_MAX+1)):
  - Increments, saturating, on a data grant while eff_if is high.
  - Clears on a fetch grant or whenever if_req is low.
- mem_complete is ignored outside BUSY.
- Requester rule: the requester drops req on the edge where it samples done. The arbiter never re-grants the same transaction.

## Timing
- Reset (async) values: state IDLE; all outputs 0; streak 0; kill 0.
- Reset mid-transaction abandons it. No done pulse is issued, and a late mem_complete is ignored.
- Grant decision is made in cycle T (IDLE). mem_enable is asserted from T+1.
- mem_complete at cycle C gives done at C+1 and IDLE at C+2.
- Minimum request-to-done latency is 2 cycles (complete at T+1). Back-to-back throughput is one transaction per 3 cycles when the cache completes immediately.
- if_data and dm_data hold their value until the next completion for that side.

## Structure
- mem_arb_pkg: state enum (ARB_IDLE, ARB_BUSY, ARB_RESP) and the owner encoding (OWN_I = 0, OWN_D = 1).
- One sub-module, mem_arb_prio: combinational winner select from eff_if, dm_req and streak.
- Streak, kill, FSM and data registers live in mem_port_arbiter.

## Test plan
- **Single fetch:** if_req, if_addr = 0x1000; cache completes 3 cycles after enable with 0xDEAD → mem_addr = 0x1000 and mem_wr_en = 0; if_done one cycle with if_data = 0xDEAD; dm_done stays 0.
- **Simultaneous requests, STARVE_MAX = 2:** if_req held; dm_req reissued immediately after each dm_done → grant order D, D, I, D, D, I.
- **Store:** dm_req, dm_wr_en = 1, addr 0x2008, value 0x55 → mem_wr_en = 1, mem_wr_value = 0x55 held through BUSY; dm_done pulses once.
- **Flush during fetch BUSY:** flush one cycle at BUSY+1 → no if_done; the next transaction proceeds normally. Flush in IDLE with only if_req high → no grant that cycle.
- **rst mid-BUSY:** state IDLE, mem_enable = 0 asynchronously. A mem_complete arriving later produces no done.
- **Cache completes in first enable cycle:** done at T+2 and mem_enable high for exactly one cycle.
